// File: rtl/fp32_pkg.sv
// fp32_pkg: IEEE-754 single-precision field widths, constants and multiplier FSM states.
package fp32_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    typedef enum logic [2:0] {IDLE, CHECK, MUL, NORM, DONE} state_t;
endpackage

// File: rtl/mant_mul_seq.sv
// mant_mul_seq: sequential shift-add mantissa multiplier, one multiplier bit per step.
module mant_mul_seq
    import fp32_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [MAN_W:0]     a_i,
    input  logic [MAN_W:0]     b_i,
    output logic [2*MAN_W+1:0] p_o,
    output logic               done_o
);
    logic [2*MAN_W+1:0] mcand_q, mcand_d, p_q, p_d;
    logic [MAN_W:0]     mplier_q, mplier_d;
    logic [4:0]         cnt_q, cnt_d;
    always_comb begin
        mcand_d  = load_i ? {{(MAN_W+1){1'b0}}, a_i} : step_i ? mcand_q << 1 : mcand_q;
        mplier_d = load_i ? b_i : step_i ? mplier_q >> 1 : mplier_q;
        p_d      = load_i ? '0 : (step_i && mplier_q[0]) ? p_q + mcand_q : p_q;
        cnt_d    = load_i ? '0 : step_i ? cnt_q + 5'd1 : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
        end
    end
    assign p_o = p_q;
    // High during the final (24th) step so the controller leaves MUL on that same edge.
    assign done_o = (cnt_q == 5'(MAN_W));
endmodule

// File: rtl/mul_fsm.sv
// mul_fsm: multi-cycle IEEE-754 single multiplier with edge-triggered start, special-case
// classification, truncating normalisation and a one-cycle result strobe.
module mul_fsm
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        r_i,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic        r_o,
    output logic        err
);
    state_t             state_q, state_d;
    logic               r_i_q;
    logic [31:0]        a_q, a_d, b_q, b_d, sres_q, sres_d, res_q, res_d;
    logic               sign_q, sign_d, spec_q, spec_d, serr_q, serr_d, err_q, err_d;
    logic signed [9:0]  exp_q, exp_d, e_n;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb, man;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               s_nan, s_inf, special, sign, start, load, step, last;
    logic [47:0]        p;
    logic [31:0]        sres, packed_res;
    assign start = r_i & ~r_i_q;
    assign {ea, ma} = a_q[30:0];
    assign {eb, mb} = b_q[30:0];
    assign sign   = a_q[31] ^ b_q[31];
    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_inf  = (&ea) && !(|ma);
    assign b_inf  = (&eb) && !(|mb);
    assign a_zero = !(|ea);
    assign b_zero = !(|eb);
    assign s_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign s_inf  = a_inf || b_inf;
    assign special = s_nan || s_inf || a_zero || b_zero;
    assign sres = s_nan ? QNAN : s_inf ? {sign, POS_INF[30:0]} : {sign, 31'b0};
    assign e_n = exp_q + 10'(p[47]);
    assign man = p[47] ? p[46:24] : p[45:23];
    assign packed_res = (e_n >= 10'sd255) ? {sign_q, POS_INF[30:0]} :
                        (e_n <= 10'sd0)   ? {sign_q, 31'b0} : {sign_q, e_n[7:0], man};
    mant_mul_seq u_mant (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .a_i    ({1'b1, ma}),
        .b_i    ({1'b1, mb}),
        .p_o    (p),
        .done_o (last)
    );
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        spec_d  = spec_q;
        sres_d  = sres_q;
        serr_d  = serr_q;
        exp_d   = exp_q;
        res_d   = res_q;
        err_d   = err_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                a_d     = start ? a : a_q;
                b_d     = start ? b : b_q;
                state_d = start ? CHECK : IDLE;
            end
            CHECK: begin
                sign_d  = sign;
                spec_d  = special;
                sres_d  = sres;
                serr_d  = s_nan || s_inf;
                exp_d   = 10'(ea) + 10'(eb) - 10'(BIAS);
                load    = 1'b1;
                // Specials skip MUL but share the NORM write-back cycle.
                state_d = special ? NORM : MUL;
            end
            MUL: begin
                step    = 1'b1;
                state_d = last ? NORM : MUL;
            end
            NORM: begin
                res_d   = spec_q ? sres_q : packed_res;
                err_d   = spec_q ? serr_q : (e_n >= 10'sd255);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_i_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            spec_q  <= 1'b0;
            sres_q  <= '0;
            serr_q  <= 1'b0;
            exp_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_i_q   <= r_i;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            spec_q  <= spec_d;
            sres_q  <= sres_d;
            serr_q  <= serr_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
    assign res = res_q;
    assign err = err_q;
    assign r_o = (state_q == DONE);
endmodule

// File: tb/tb_mul_fsm.sv
// tb_mul_fsm: scoreboard bench for mul_fsm; expected results are queued at start and
// checked (value, flag, latency) when r_o pulses.
module tb_mul_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_i = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] res;
    logic        r_o;
    logic        err;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ro_cnt = 0;
    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
        int          cap;
    } exp_t;
    exp_t sb[$];
    mul_fsm dut (
        .clk (clk),
        .rst (rst),
        .r_i (r_i),
        .a   (a),
        .b   (b),
        .res (res),
        .r_o (r_o),
        .err (err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (r_o) begin
            ro_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_r_o: got r_o=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (res !== e.res) begin
                    failures++;
                    $display("FAIL result: got res=%08h, expected %08h", res, e.res);
                end
                if (err !== e.err) begin
                    failures++;
                    $display("FAIL err_flag: got err=%0b, expected %0b (res %08h)", err, e.err, e.res);
                end
                if (cyc - e.cap !== e.lat) begin
                    failures++;
                    $display("FAIL latency: got %0d cycles, expected %0d (res %08h)", cyc - e.cap, e.lat, e.res);
                end
            end
        end
    end
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev, input logic ee, input int lat);
        exp_t e;
        e.res = ev;
        e.err = ee;
        e.lat = lat;
        e.cap = cyc + 1;
        a = av;
        b = bv;
        r_i = 1'b1;
        sb.push_back(e);
        tick();
        r_i = 1'b0;
    endtask
    task automatic wait_ro();
        int n0 = ro_cnt;
        int k = 0;
        while (ro_cnt == n0 && k < 60) begin
            tick();
            k++;
        end
        checks++;
        if (ro_cnt == n0) begin
            failures++;
            $display("FAIL ro_timeout: got no r_o within 60 cycles, expected one");
            sb.delete();
        end
    endtask
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev, input logic ee, input int lat);
        start_op(av, bv, ev, ee, lat);
        wait_ro();
        tick();
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks += 3;
        if (res !== 32'h0) begin failures++; $display("FAIL reset_res: got %08h, expected 00000000", res); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b, expected 0", err); end
        if (r_o !== 1'b0) begin failures++; $display("FAIL reset_r_o: got %0b, expected 0", r_o); end
        rst = 1'b0;
        tick();
    endtask
    task automatic test_normal();
        logic [31:0] va[9] = '{32'h40A00000, 32'h40000000, 32'h3FC00000, 32'h40400000, 32'h3F800001,
                               32'h3FFFFFFF, 32'h7F000000, 32'h00800000, 32'h80800000};
        logic [31:0] vb[9] = '{32'h40E00000, 32'h3F000000, 32'h3FC00000, 32'hC0800000, 32'h3F800001,
                               32'h3FFFFFFF, 32'h40000000, 32'h3F000000, 32'h3F000000};
        logic [31:0] vr[9] = '{32'h420C0000, 32'h3F800000, 32'h40100000, 32'hC1400000, 32'h3F800002,
                               32'h407FFFFE, 32'h7F800000, 32'h00000000, 32'h80000000};
        logic        ve[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) run_op(va[i], vb[i], vr[i], ve[i], 26);
    endtask
    task automatic test_special();
        logic [31:0] va[7] = '{32'h80000000, 32'h7FC00000, 32'h7F800000, 32'hFF800000,
                               32'h00000001, 32'h3F800000, 32'h7F800000};
        logic [31:0] vb[7] = '{32'h40A00000, 32'h3F800000, 32'h00000000, 32'h40000000,
                               32'h3F800000, 32'hFF800001, 32'hBF800000};
        logic [31:0] vr[7] = '{32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                               32'h00000000, 32'h7FC00000, 32'hFF800000};
        logic        ve[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) run_op(va[i], vb[i], vr[i], ve[i], 2);
    endtask
    task automatic test_held();
        int n0 = ro_cnt;
        exp_t e;
        e.res = 32'h420C0000;
        e.err = 1'b0;
        e.lat = 26;
        e.cap = cyc + 1;
        a = 32'h40A00000;
        b = 32'h40E00000;
        r_i = 1'b1;
        sb.push_back(e);
        tick();
        a = 32'h3F800000;
        b = 32'h40400000;
        repeat (4) tick();
        r_i = 1'b0;
        wait_ro();
        repeat (30) tick();
        checks++;
        if (ro_cnt - n0 !== 1) begin
            failures++;
            $display("FAIL held_r_i_pulses: got %0d r_o pulses, expected 1", ro_cnt - n0);
        end
    endtask
    task automatic test_back_to_back();
        int n0 = ro_cnt;
        start_op(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 26);
        repeat (8) tick();
        a = 32'h3F800000;
        b = 32'h40000000;
        r_i = 1'b1;
        tick();
        r_i = 1'b0;
        wait_ro();
        tick();
        start_op(32'h40A00000, 32'h40E00000, 32'h420C0000, 1'b0, 26);
        wait_ro();
        tick();
        start_op(32'h7F800000, 32'hBF800000, 32'hFF800000, 1'b1, 2);
        wait_ro();
        repeat (30) tick();
        checks++;
        if (ro_cnt - n0 !== 3) begin
            failures++;
            $display("FAIL back_to_back_pulses: got %0d r_o pulses, expected 3", ro_cnt - n0);
        end
    endtask
    task automatic test_reset_mid();
        int n0;
        start_op(32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 26);
        repeat (11) tick();
        rst = 1'b1;
        #1;
        checks += 3;
        if (res !== 32'h0) begin failures++; $display("FAIL mid_reset_res: got %08h, expected 00000000", res); end
        if (err !== 1'b0) begin failures++; $display("FAIL mid_reset_err: got %0b, expected 0", err); end
        if (r_o !== 1'b0) begin failures++; $display("FAIL mid_reset_r_o: got %0b, expected 0", r_o); end
        sb.delete();
        n0 = ro_cnt;
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        checks++;
        if (ro_cnt !== n0) begin
            failures++;
            $display("FAIL aborted_r_o: got %0d r_o pulses after reset, expected 0", ro_cnt - n0);
        end
        run_op(32'h40A00000, 32'h40E00000, 32'h420C0000, 1'b0, 26);
    endtask
    initial begin
        test_reset();
        test_normal();
        test_special();
        test_held();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
